// File: rtl/aes_pkg.sv
// aes_pkg: shared AES block width, block type and counter-generator state encoding
package aes_pkg;
  localparam int AES_BLOCK_W = 128;
  typedef logic [AES_BLOCK_W-1:0] aes_block_t;
  typedef enum logic [1:0] {IDLE, WAIT_KEY, SEND} ctr_gen_state_t;
endpackage

// File: rtl/aes_ctr_inc.sv
// aes_ctr_inc: combinational counter-block increment (blk_in -> blk_out, low CTR_WIDTH bits wrap, upper nonce bits pass through)
module aes_ctr_inc
  import aes_pkg::*;
#(
  parameter int CTR_WIDTH = 128
) (
  input  aes_block_t blk_in,
  output aes_block_t blk_out
);
  if (CTR_WIDTH >= AES_BLOCK_W) begin : g_full
    assign blk_out = blk_in + aes_block_t'(1);
  end else begin : g_part
    assign blk_out = {blk_in[AES_BLOCK_W-1:CTR_WIDTH], blk_in[CTR_WIDTH-1:0] + CTR_WIDTH'(1)};
  end
endmodule

// File: rtl/aes_ctr_block_gen.sv
// aes_ctr_block_gen: AES-CTR counter-block AXIS source (pi_start/pi_iv/pi_num_blocks request in, key/credit gated m_axis_* out, po_busy/po_done/po_credits/po_credit_err status)
module aes_ctr_block_gen
  import aes_pkg::*;
#(
  parameter int CTR_WIDTH   = 128,
  parameter int MAX_CREDITS = 16,
  parameter int LEN_WIDTH   = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               pi_start,
  input  logic [AES_BLOCK_W-1:0]             pi_iv,
  input  logic [LEN_WIDTH-1:0]               pi_num_blocks,
  input  logic                               pi_key_ready,
  input  logic                               pi_credit_return,
  input  logic                               m_axis_tready,
  output logic                               m_axis_tvalid,
  output logic [AES_BLOCK_W-1:0]             m_axis_tdata,
  output logic                               m_axis_tlast,
  output logic                               po_busy,
  output logic                               po_done,
  output logic [$clog2(MAX_CREDITS+1)-1:0]   po_credits,
  output logic                               po_credit_err
);
  localparam int CRW = $clog2(MAX_CREDITS+1);
  localparam logic [CRW-1:0] CRED_MAX = CRW'(MAX_CREDITS);
  ctr_gen_state_t state, state_d;
  aes_block_t ctr, ctr_next;
  logic [LEN_WIDTH-1:0] remaining;
  logic [CRW-1:0] credits;
  logic done, err, hs, last_hs, start_ok;
  aes_ctr_inc #(.CTR_WIDTH(CTR_WIDTH)) u_inc (.blk_in(ctr), .blk_out(ctr_next));
  assign hs = m_axis_tvalid & m_axis_tready;
  assign last_hs = hs & (remaining == LEN_WIDTH'(1));
  assign start_ok = (state == IDLE) & pi_start;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:     state_d = (pi_start && pi_num_blocks != '0) ? WAIT_KEY : IDLE;
      WAIT_KEY: state_d = pi_key_ready ? SEND : WAIT_KEY;
      SEND:     state_d = last_hs ? IDLE : SEND;
      default:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ctr       <= '0;
      remaining <= '0;
      credits   <= CRED_MAX;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= state_d;
      if (start_ok) begin
        ctr       <= pi_iv;
        remaining <= pi_num_blocks;
      end else if (hs) begin
        ctr       <= ctr_next;
        remaining <= remaining - LEN_WIDTH'(1);
      end
      done <= (start_ok && pi_num_blocks == '0) || last_hs;
      err  <= err | (pi_credit_return && credits == CRED_MAX);
      // a return arriving with a handshake cancels out; a return with nothing outstanding saturates
      if (hs && !pi_credit_return) credits <= credits - CRW'(1);
      else if (!hs && pi_credit_return && credits != CRED_MAX) credits <= credits + CRW'(1);
    end
  end
  assign m_axis_tvalid = (state == SEND) && (credits != '0);
  assign m_axis_tdata  = ctr;
  assign m_axis_tlast  = (state == SEND) && (remaining == LEN_WIDTH'(1));
  assign po_busy       = state != IDLE;
  assign po_done       = done;
  assign po_credits    = credits;
  assign po_credit_err = err;
endmodule

// File: tb/tb_aes_ctr_block_gen.sv
// tb_aes_ctr_block_gen: directed bench with a behavioural reference model for two parameterisations
module tb_aes_ctr_block_gen;
  logic clk = 0, rst_n = 0, key = 1, tready = 1;
  logic st[2], rt[2];
  logic [127:0] ivs[2];
  logic [31:0] nbs[2];
  logic tvalid[2], tlast[2], busy[2], done[2], err[2];
  logic [127:0] tdata[2];
  logic [4:0] cr0;
  logic [2:0] cr1;
  logic [7:0] cred_o[2];
  int errors = 0, checks = 0;
  logic [127:0] q0[$], q1[$];
  logic l0[$], l1[$];
  logic [127:0] hold;
  always #5 clk = ~clk;
  assign cred_o[0] = 8'(cr0);
  assign cred_o[1] = 8'(cr1);

  aes_ctr_block_gen u0 (
    .clk(clk), .rst_n(rst_n), .pi_start(st[0]), .pi_iv(ivs[0]), .pi_num_blocks(nbs[0]),
    .pi_key_ready(key), .pi_credit_return(rt[0]), .m_axis_tready(tready),
    .m_axis_tvalid(tvalid[0]), .m_axis_tdata(tdata[0]), .m_axis_tlast(tlast[0]),
    .po_busy(busy[0]), .po_done(done[0]), .po_credits(cr0), .po_credit_err(err[0]));

  aes_ctr_block_gen #(.CTR_WIDTH(32), .MAX_CREDITS(4)) u1 (
    .clk(clk), .rst_n(rst_n), .pi_start(st[1]), .pi_iv(ivs[1]), .pi_num_blocks(nbs[1]),
    .pi_key_ready(key), .pi_credit_return(rt[1]), .m_axis_tready(tready),
    .m_axis_tvalid(tvalid[1]), .m_axis_tdata(tdata[1]), .m_axis_tlast(tlast[1]),
    .po_busy(busy[1]), .po_done(done[1]), .po_credits(cr1), .po_credit_err(err[1]));

  // reference model: request = (iv, n), progress = beats sent; credits = capacity minus outstanding
  int cwv[2] = '{128, 32};
  int maxc[2] = '{16, 4};
  int ph[2], mcred[2];
  longint mn[2], ms[2];
  logic [127:0] miv[2];
  bit mdone[2], merr[2];

  function automatic bit m_hs(int i);
    return ph[i] == 2 && mcred[i] != 0 && tready;
  endfunction
  function automatic bit m_fin(int i);
    return m_hs(i) && ms[i] == mn[i] - 1;
  endfunction
  function automatic logic [127:0] exp_data(int i);
    logic [127:0] mask = (cwv[i] >= 128) ? '1 : ((128'(1) << cwv[i]) - 128'(1));
    logic [127:0] sum = miv[i] + 128'(ms[i]);
    return (miv[i] & ~mask) | (sum & mask);
  endfunction

  always @(posedge clk or negedge rst_n)
    for (int i = 0; i < 2; i++)
      if (!rst_n) begin
        ph[i] <= 0; mcred[i] <= maxc[i]; mdone[i] <= 0; merr[i] <= 0;
        ms[i] <= 0; mn[i] <= 0; miv[i] <= '0;
      end else begin
        mdone[i] <= (ph[i] == 0 && st[i] && nbs[i] == 0) || m_fin(i);
        merr[i]  <= merr[i] | (rt[i] && mcred[i] == maxc[i]);
        mcred[i] <= (rt[i] && !m_hs(i) && mcred[i] == maxc[i]) ? mcred[i]
                    : mcred[i] - int'(m_hs(i)) + int'(rt[i]);
        if (ph[i] == 0 && st[i] && nbs[i] != 0) begin
          miv[i] <= ivs[i]; mn[i] <= longint'(nbs[i]); ms[i] <= 0; ph[i] <= 1;
        end else if (ph[i] == 1 && key) ph[i] <= 2;
        else if (m_hs(i)) begin
          ms[i] <= ms[i] + 1;
          if (m_fin(i)) ph[i] <= 0;
        end
      end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk)
    if (rst_n)
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("u%0d tvalid", i), 128'(tvalid[i]), 128'(ph[i] == 2 && mcred[i] != 0));
        chk($sformatf("u%0d tlast", i), 128'(tlast[i]), 128'(ph[i] == 2 && ms[i] == mn[i] - 1));
        chk($sformatf("u%0d busy", i), 128'(busy[i]), 128'(ph[i] != 0));
        chk($sformatf("u%0d done", i), 128'(done[i]), 128'(mdone[i]));
        chk($sformatf("u%0d credits", i), 128'(cred_o[i]), 128'(mcred[i]));
        chk($sformatf("u%0d credit_err", i), 128'(err[i]), 128'(merr[i]));
        if (ph[i] == 2 && mcred[i] != 0) chk($sformatf("u%0d tdata", i), tdata[i], exp_data(i));
      end

  always @(negedge clk)
    if (rst_n) begin
      if (tvalid[0] && tready) begin q0.push_back(tdata[0]); l0.push_back(tlast[0]); end
      if (tvalid[1] && tready) begin q1.push_back(tdata[1]); l1.push_back(tlast[1]); end
    end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic start_req(input int i, input logic [127:0] iv, input logic [31:0] n);
    st[i] = 1; ivs[i] = iv; nbs[i] = n;
    tick(1);
    st[i] = 0;
  endtask
  task automatic ret_n(input int i, input int k);
    rt[i] = 1; tick(k); rt[i] = 0;
  endtask
  task automatic wait_done(input int i, input int budget);
    int k = 0;
    while (!done[i] && k < budget) begin tick(1); k++; end
    chk($sformatf("u%0d done within budget", i), 128'(done[i]), 128'(1));
  endtask

  initial begin
    st = '{0, 0}; rt = '{0, 0}; ivs = '{'0, '0}; nbs = '{0, 0};
    tick(3);
    chk("reset tvalid", 128'(tvalid[0]), 0);
    chk("reset tdata", tdata[0], 0);
    chk("reset busy", 128'(busy[0]), 0);
    chk("reset credits u0", 128'(cr0), 16);
    chk("reset credits u1", 128'(cr1), 4);
    rst_n = 1;
    tick(1);
    // NIST SP800-38A counter sequence
    start_req(0, 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF, 4);
    wait_done(0, 20);
    chk("nist beats", 128'(q0.size()), 4);
    chk("nist b1", q0[0], 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);
    chk("nist b2", q0[1], 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFF00);
    chk("nist b3", q0[2], 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFF01);
    chk("nist b4", q0[3], 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFF02);
    chk("nist tlast b3", 128'(l0[2]), 0);
    chk("nist tlast b4", 128'(l0[3]), 1);
    tick(1);
    chk("nist done one cycle", 128'(done[0]), 0);
    ret_n(0, 4);
    // 32-bit counter wrap keeps the nonce
    start_req(1, 128'h0123456789ABCDEF00000000FFFFFFFF, 2);
    wait_done(1, 20);
    chk("wrap b1", q1[0], 128'h0123456789ABCDEF00000000FFFFFFFF);
    chk("wrap b2", q1[1], 128'h0123456789ABCDEF0000000000000000);
    ret_n(1, 2);
    // credit exhaustion with MAX_CREDITS=4
    q1.delete(); l1.delete();
    start_req(1, 128'h10, 6);
    tick(12);
    chk("credits beats", 128'(q1.size()), 4);
    chk("credits zero", 128'(cr1), 0);
    chk("credits tvalid low", 128'(tvalid[1]), 0);
    ret_n(1, 1);
    tick(3);
    chk("credits beat5", 128'(q1.size()), 5);
    chk("credits b5 data", q1[4], 128'h14);
    ret_n(1, 1);
    wait_done(1, 10);
    chk("credits beat6", 128'(q1.size()), 6);
    chk("credits tlast b6", 128'(l1[5]), 1);
    ret_n(1, 4);
    // backpressure holds data
    q0.delete(); l0.delete();
    start_req(0, 128'h000102030405060708090A0B0C0D0E0F, 8);
    tick(3);
    tready = 0;
    hold = tdata[0];
    chk("bp held value", hold, 128'h000102030405060708090A0B0C0D0E11);
    for (int k = 0; k < 5; k++) begin
      tick(1);
      chk("bp tvalid held", 128'(tvalid[0]), 1);
      chk("bp tdata held", tdata[0], hold);
    end
    tready = 1;
    wait_done(0, 20);
    chk("bp beats", 128'(q0.size()), 8);
    chk("bp last", q0[7], 128'h000102030405060708090A0B0C0D0E16);
    ret_n(0, 8);
    // key gating and start-while-busy
    q0.delete(); l0.delete();
    key = 0;
    start_req(0, 128'hAAAA0000, 3);
    tick(4);
    chk("key busy", 128'(busy[0]), 1);
    chk("key no tvalid", 128'(tvalid[0]), 0);
    start_req(0, 128'hBBBB0000, 5);
    key = 1;
    tick(1);
    chk("key first beat", 128'(tvalid[0]), 1);
    chk("key first data", tdata[0], 128'hAAAA0000);
    wait_done(0, 20);
    chk("busy start ignored", 128'(q0.size()), 3);
    chk("busy start last", q0[2], 128'hAAAA0002);
    ret_n(0, 3);
    // zero-length request
    q0.delete();
    start_req(0, 128'hCCCC, 0);
    chk("zero done", 128'(done[0]), 1);
    chk("zero busy", 128'(busy[0]), 0);
    tick(1);
    chk("zero done drop", 128'(done[0]), 0);
    chk("zero no beats", 128'(q0.size()), 0);
    // credit return at full
    chk("full credits", 128'(cr0), 16);
    ret_n(0, 1);
    chk("overflow err", 128'(err[0]), 1);
    chk("overflow saturate", 128'(cr0), 16);
    // reset mid-run
    start_req(0, 128'hDDDD0000, 10);
    tick(3);
    rst_n = 0;
    #1;
    chk("rst tvalid", 128'(tvalid[0]), 0);
    chk("rst busy", 128'(busy[0]), 0);
    chk("rst credits", 128'(cr0), 16);
    chk("rst err", 128'(err[0]), 0);
    tick(2);
    rst_n = 1;
    q0.delete();
    start_req(0, 128'hEEEE00FF, 2);
    wait_done(0, 20);
    chk("post-rst b1", q0[0], 128'hEEEE00FF);
    chk("post-rst b2", q0[1], 128'hEEEE0100);
    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
